// File: rtl/neuron_layer_driver.sv
// neuron_layer_driver: initiator for one generated neuron-layer output stage.
// Preloads the neuron weight/bias memory once after reset, gathers an N_IN
// element input vector from the upstream stream, pulses the neuron reset,
// requests a compute and forwards the activation on a valid/ready stream.
// Optional feature macro: LAYER_DRV_TIMEOUT_EN bounds the wait for ack__1 to
// TIMEOUT cycles and reports expiry on the sticky err flag.
module neuron_layer_driver #(
  parameter int DATA_W      = 8,
  parameter int N_IN        = 2,
  parameter int FILL_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   n_rst,
  output logic                   fill,
  output logic                   req,
  output logic [N_IN*DATA_W-1:0] x_bus,
  input  logic                   ack__1,
  input  logic [DATA_W-1:0]      y,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   err
);

  // One counter serves both the preload length and the ack timeout.
  localparam int CNT_MAX = (FILL_CYCLES > TIMEOUT) ? FILL_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_IN - 1);
`ifdef LAYER_DRV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_COLLECT = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_REQ     = 3'd4,
    ST_OUT     = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [N_IN*DATA_W-1:0]  x_bus_r, x_bus_s;
  logic [DATA_W-1:0]       m_data_r, m_data_s;
  logic                    err_r, err_s;
  logic                    s_ready_r, n_rst_r, fill_r, req_r, m_valid_r;

  // Next-state, datapath update and counter logic for the driver sequence.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    x_bus_s  = x_bus_r;
    m_data_s = m_data_r;
    err_s    = err_r;
    case (state_r)
      ST_RESET: begin
        state_s = ST_PRELOAD;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_PRELOAD: begin
        if (cnt_r == FILL_LAST) begin
          state_s = ST_COLLECT;
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        if (s_valid && s_ready_r) begin
          // Only the element addressed by idx takes the new sample.
          for (int i = 0; i < N_IN; i++) begin
            if (idx_r == IDX_W'(i)) begin
              x_bus_s[i*DATA_W +: DATA_W] = s_data;
            end else begin
              x_bus_s[i*DATA_W +: DATA_W] = x_bus_r[i*DATA_W +: DATA_W];
            end
          end
          if (idx_r == IDX_LAST) begin
            idx_s   = {IDX_W{1'b0}};
            state_s = ST_CLEAR;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_CLEAR: begin
        state_s = ST_REQ;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_REQ: begin
        if (ack__1) begin
          m_data_s = y;
          state_s  = ST_OUT;
        end
`ifdef LAYER_DRV_TIMEOUT_EN
        else if (cnt_r == TO_LAST) begin
          // Neuron never answered: hand a zero result downstream and flag it.
          m_data_s = {DATA_W{1'b0}};
          err_s    = 1'b1;
          state_s  = ST_OUT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_s = ST_REQ;
        end
`endif
      end
      ST_OUT: begin
        if (m_valid_r && m_ready) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_RESET;
      end
    endcase
  end

  // State, datapath and registered strobe outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RESET;
      cnt_r     <= {CNT_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      x_bus_r   <= {(N_IN*DATA_W){1'b0}};
      m_data_r  <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      s_ready_r <= 1'b0;
      n_rst_r   <= 1'b1;
      fill_r    <= 1'b0;
      req_r     <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      x_bus_r   <= x_bus_s;
      m_data_r  <= m_data_s;
      err_r     <= err_s;
      s_ready_r <= (state_s == ST_COLLECT);
      n_rst_r   <= (state_s == ST_RESET) || (state_s == ST_CLEAR);
      fill_r    <= (state_s == ST_PRELOAD);
      req_r     <= (state_s == ST_REQ);
      m_valid_r <= (state_s == ST_OUT);
    end
  end

  assign s_ready = s_ready_r;
  assign n_rst   = n_rst_r;
  assign fill    = fill_r;
  assign req     = req_r;
  assign x_bus   = x_bus_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign err     = err_r;

endmodule
